reg_bus_arbiter: RTL and testbench
==================================

// Module: reg_bus_arbiter
// PURPOSE
//   Shares the single internal register bus (reg_raddr/reg_waddr/reg_wdata/reg_wen, blk_wstart/blk_wen, reg_rdata/reg_rwait)
//   between NUM_REQ host-side requesters: 0=Firewire, 1=Ethernet, 2=PS7.
//   Sits between those interfaces and the board-specific register space (QLA, DS2505, etc.).
//   Serializes single reads and single writes; a block write holds the bus for its full duration.
// PARAMETERS
//   NUM_REQ    3    number of requesters; index 0 is highest priority on reset
//   RWAIT_MAX  15   max cycles reg_rwait may hold a read (used only with REG_ARB_TIMEOUT_EN)
// PORTS
//   sysclk      in   1          system clock, 49.152 MHz
//   reset       in   1          synchronous, active-high
//   req_valid   in   NUM_REQ    request pending, held until req_done for that index
//   req_write   in   NUM_REQ    1=write, 0=read
//   req_blk     in   NUM_REQ    write is part of a block; keep the grant until req_last
//   req_last    in   NUM_REQ    final word of a block write
//   req_addr    in   16*NUM_REQ register address, one slice per requester
//   req_wdata   in   32*NUM_REQ write data, one slice per requester
//   req_done    out  NUM_REQ    1-cycle pulse: read data valid, or write issued
//   req_err     out  NUM_REQ    1-cycle pulse with req_done on read timeout (0 when timeout feature is compiled out)
//   req_rdata   out  32         read data; valid while req_done is high
//   grant_id    out  2          currently granted index; 3 = none
//   reg_raddr   out  16         register bus read address
//   reg_waddr   out  16         register bus write address
//   reg_wdata   out  32         register bus write data
//   reg_wen     out  1          single-cycle write strobe
//   blk_wstart  out  1          1-cycle pulse before the first word of a block write
//   blk_wen     out  1          1-cycle pulse after the last word of a block write
//   reg_rdata   in   32         register read data
//   reg_rwait   in   1          read wait state from the register space
// BEHAVIOUR
//   Reset values: all outputs 0, except grant_id=3. Round-robin pointer is 0 and the FSM is in IDLE.
//   FSM states: IDLE, RD_ADDR, RD_WAIT, WR, BLK_START, BLK_WR, BLK_HOLD, BLK_END.
//   IDLE:
//     Pick the first valid requester at or after rr_ptr, wrapping modulo NUM_REQ.
//     Set grant_id. Set rr_ptr = granted+1 (wraps).
//     Go to RD_ADDR, WR, or BLK_START according to req_write and req_blk.
//   Read:
//     RD_ADDR: register reg_raddr from the granted slice.
//     RD_WAIT: wait at least 1 cycle. Sample reg_rdata on the first RD_WAIT cycle with reg_rwait=0.
//     On that sample: req_done=1, return to IDLE.
//     Minimum latency, req_valid to req_done: 3 cycles.
//   Single write:
//     WR: reg_waddr/reg_wdata driven and reg_wen=1 for exactly 1 cycle; req_done pulses in the same cycle.
//     Next state IDLE.
//   Block write:
//     BLK_START: blk_wstart=1 for 1 cycle.
//     BLK_WR: one reg_wen and one req_done per accepted word.
//     BLK_HOLD: entered when the granted req_valid is low. Grant is kept and no other requester is served.
//     The word with req_last=1 goes to BLK_END: blk_wen=1 for 1 cycle, then IDLE.
//   Write address/data hold their last value when reg_wen=0. reg_raddr holds its last value outside reads.
//   Grant switches only in IDLE, so there is at least 1 idle cycle between transactions.
//   If the granted requester drops req_valid outside BLK_HOLD, its transaction still completes.
//     That req_done pulse is ignored by the requester.
//   If several requests are valid at once, round-robin decides; a newly raised request never preempts the current grant.
//   If NUM_REQ is not a power of two, the rr_ptr wrap compares against NUM_REQ-1, not a bit mask.
//   reset in any state: synchronous return to IDLE on the next edge.
//     No blk_wen is emitted for an aborted block. req_done, req_err, reg_wen, blk_* are forced low the same cycle.
// CONFIGURATION
//   REG_ARB_TIMEOUT_EN defined:
//     A counter in RD_WAIT counts reg_rwait=1 cycles.
//     On reaching RWAIT_MAX: req_done=1, req_err=1, req_rdata=32'h0, go to IDLE.
//   REG_ARB_TIMEOUT_EN undefined:
//     RD_WAIT waits indefinitely. req_err is tied to 0 and the counter is not built.
// STRUCTURE
//   Shared package/include (alongside Constants.v):
//     FSM state encodings
//     GRANT_NONE = 2'd3
//     requester indices REQ_FW=0, REQ_ETH=1, REQ_PS=2
//   Sub-module rr_select:
//     combinational round-robin pick from (req_valid, rr_ptr) to (hit, index). Reusable for other shared resources.
//   The FSM and datapath registers stay in reg_bus_arbiter.
// TESTING
//   1. Req 1 reads addr 16'h0010, reg_rwait=0, reg_rdata=32'hCAFE0001
//      -> req_done[1] 3 cycles after req_valid; req_rdata=32'hCAFE0001.
//   2. All 3 requesters issue reads in the same cycle, repeatedly
//      -> grant order 0,1,2,0,1,2; exactly 1 idle cycle between grants.
//   3. Req 0 block write of 4 words with a 2-cycle req_valid gap after word 2, while req 2 also requests
//      -> blk_wstart, 4 reg_wen pulses, blk_wen; req 2 granted only after blk_wen.
//   4. Read with reg_rwait=1 for 5 cycles -> rdata sampled on the cycle rwait falls; req_done 8 cycles after req_valid.
//   5. reset pulsed during BLK_HOLD -> next cycle grant_id=3, no blk_wen; next request is served normally.
//   6. REG_ARB_TIMEOUT_EN defined, reg_rwait stuck at 1 -> req_done and req_err after 15 wait cycles, req_rdata=0.
//      Macro undefined, same stimulus -> no req_done within 100 cycles.

Source files
------------

// File: rtl/reg_bus_arbiter_pkg.sv
// reg_bus_arbiter_pkg: shared FSM encoding, grant constants and round-robin helper for the register bus arbiter
package reg_bus_arbiter_pkg;
  typedef enum logic [2:0] {IDLE, RD_ADDR, RD_WAIT, WR, BLK_START, BLK_WR, BLK_HOLD, BLK_END} state_t;
  localparam int IDX_W = 2;
  localparam logic [IDX_W-1:0] GRANT_NONE = 2'd3;
  localparam logic [IDX_W-1:0] REQ_FW = 2'd0;
  localparam logic [IDX_W-1:0] REQ_ETH = 2'd1;
  localparam logic [IDX_W-1:0] REQ_PS = 2'd2;
  function automatic logic [IDX_W-1:0] rr_next(input logic [IDX_W-1:0] i, input int n);
    return (int'(i) == n - 1) ? '0 : i + 1'b1;
  endfunction
endpackage

// File: rtl/reg_bus_arbiter_if.sv
// reg_bus_arbiter_if: requester handshake plus register bus; master is the arbiter, slave is requesters and register space
interface reg_bus_arbiter_if #(parameter int NUM_REQ = 3);
  logic [NUM_REQ-1:0] req_valid, req_write, req_blk, req_last, req_done, req_err;
  logic [16*NUM_REQ-1:0] req_addr;
  logic [32*NUM_REQ-1:0] req_wdata;
  logic [31:0] req_rdata;
  logic [1:0] grant_id;
  logic [15:0] reg_raddr, reg_waddr;
  logic [31:0] reg_wdata, reg_rdata;
  logic reg_wen, blk_wstart, blk_wen, reg_rwait;
  modport master (
    input req_valid, req_write, req_blk, req_last, req_addr, req_wdata, reg_rdata, reg_rwait,
    output req_done, req_err, req_rdata, grant_id, reg_raddr, reg_waddr, reg_wdata, reg_wen, blk_wstart, blk_wen
  );
  modport slave (
    output req_valid, req_write, req_blk, req_last, req_addr, req_wdata, reg_rdata, reg_rwait,
    input req_done, req_err, req_rdata, grant_id, reg_raddr, reg_waddr, reg_wdata, reg_wen, blk_wstart, blk_wen
  );
endinterface

// File: rtl/reg_bus_arbiter_rr_select.sv
// rr_select: combinational round-robin pick of the first valid index at or after ptr, wrapping modulo N
module rr_select
  import reg_bus_arbiter_pkg::*;
#(
  parameter int N = 3
) (
  input  logic [N-1:0]     valid,
  input  logic [IDX_W-1:0] ptr,
  output logic             hit,
  output logic [IDX_W-1:0] idx
);
  logic [IDX_W-1:0] k;
  always_comb begin
    hit = |valid;
    idx = '0;
    k = '0;
    for (int i = N - 1; i >= 0; i--) begin
      k = IDX_W'((int'(ptr) + i) % N);
      if (valid[k]) idx = k;
    end
  end
endmodule

// File: rtl/reg_bus_arbiter.sv
// reg_bus_arbiter: serializes requester reads/writes/block writes onto the register bus; REG_ARB_TIMEOUT_EN adds a read timeout
module reg_bus_arbiter
  import reg_bus_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 3
`ifdef REG_ARB_TIMEOUT_EN
  , parameter int RWAIT_MAX = 15
`endif
) (
  input logic sysclk,
  input logic reset,
  reg_bus_arbiter_if.master bus
);
  state_t state;
  logic [IDX_W-1:0] rr_ptr, pick, g;
  logic hit;
  logic [15:0] addr_s [NUM_REQ];
  logic [31:0] data_s [NUM_REQ];
  for (genvar i = 0; i < NUM_REQ; i++) begin : g_slice
    assign addr_s[i] = bus.req_addr[16*i +: 16];
    assign data_s[i] = bus.req_wdata[32*i +: 32];
  end
  assign g = bus.grant_id;
  // a requester whose done is still showing has not yet had the chance to drop valid
  rr_select #(.N(NUM_REQ)) u_rr (.valid(bus.req_valid & ~bus.req_done), .ptr(rr_ptr), .hit(hit), .idx(pick));
`ifdef REG_ARB_TIMEOUT_EN
  localparam int CW = $clog2(RWAIT_MAX + 1);
  logic [CW-1:0] cnt;
`else
  assign bus.req_err = '0;
`endif
  always_ff @(posedge sysclk) begin
    if (reset) begin
      state <= IDLE;
      rr_ptr <= '0;
      bus.grant_id <= GRANT_NONE;
      bus.req_done <= '0;
      bus.req_rdata <= '0;
      bus.reg_raddr <= '0;
      bus.reg_waddr <= '0;
      bus.reg_wdata <= '0;
      bus.reg_wen <= 1'b0;
      bus.blk_wstart <= 1'b0;
      bus.blk_wen <= 1'b0;
`ifdef REG_ARB_TIMEOUT_EN
      bus.req_err <= '0;
      cnt <= '0;
`endif
    end else begin
      bus.req_done <= '0;
      bus.reg_wen <= 1'b0;
      bus.blk_wstart <= 1'b0;
      bus.blk_wen <= 1'b0;
`ifdef REG_ARB_TIMEOUT_EN
      bus.req_err <= '0;
`endif
      case (state)
        IDLE: if (hit) begin
          bus.grant_id <= pick;
          rr_ptr <= rr_next(pick, NUM_REQ);
          state <= !bus.req_write[pick] ? RD_ADDR : bus.req_blk[pick] ? BLK_START : WR;
        end
        RD_ADDR: begin
          bus.reg_raddr <= addr_s[g];
          state <= RD_WAIT;
`ifdef REG_ARB_TIMEOUT_EN
          cnt <= '0;
`endif
        end
        RD_WAIT: if (!bus.reg_rwait) begin
          bus.req_done[g] <= 1'b1;
          bus.req_rdata <= bus.reg_rdata;
          bus.grant_id <= GRANT_NONE;
          state <= IDLE;
        end
`ifdef REG_ARB_TIMEOUT_EN
        else if (cnt == CW'(RWAIT_MAX - 1)) begin
          bus.req_done[g] <= 1'b1;
          bus.req_err[g] <= 1'b1;
          bus.req_rdata <= '0;
          bus.grant_id <= GRANT_NONE;
          state <= IDLE;
        end else cnt <= cnt + 1'b1;
`endif
        WR: begin
          bus.reg_waddr <= addr_s[g];
          bus.reg_wdata <= data_s[g];
          bus.reg_wen <= 1'b1;
          bus.req_done[g] <= 1'b1;
          bus.grant_id <= GRANT_NONE;
          state <= IDLE;
        end
        BLK_START: begin
          bus.blk_wstart <= 1'b1;
          state <= BLK_WR;
        end
        BLK_WR, BLK_HOLD: if (bus.req_valid[g]) begin
          bus.reg_waddr <= addr_s[g];
          bus.reg_wdata <= data_s[g];
          bus.reg_wen <= 1'b1;
          bus.req_done[g] <= 1'b1;
          state <= bus.req_last[g] ? BLK_END : BLK_WR;
        end else state <= BLK_HOLD;
        BLK_END: begin
          bus.blk_wen <= 1'b1;
          bus.grant_id <= GRANT_NONE;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_reg_bus_arbiter.sv
// tb_reg_bus_arbiter: directed scenarios plus randomized traffic checked against a transaction-level round-robin model
module tb_reg_bus_arbiter;
  import reg_bus_arbiter_pkg::*;
  localparam int N = 3;
  logic sysclk = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int errors = 0;
  logic [31:0] env_mem [256];
  logic [31:0] ref_mem [256];
  reg_bus_arbiter_if #(.NUM_REQ(N)) bus();
  reg_bus_arbiter #(.NUM_REQ(N)) dut (.sysclk(sysclk), .reset(reset), .bus(bus));
  always #5 sysclk = ~sysclk;
  function automatic logic [7:0] mi(input logic [15:0] a);
    return {a[15:12], a[3:0]};
  endfunction
  assign bus.reg_rdata = env_mem[mi(bus.reg_raddr)];
  task automatic tick();
    @(posedge sysclk);
    #1;
    if (bus.reg_wen) env_mem[mi(bus.reg_waddr)] = bus.reg_wdata;
  endtask
  task automatic set_req(input int i, input logic v, input logic w, input logic b, input logic l,
                         input logic [15:0] a, input logic [31:0] d);
    bus.req_valid[i] = v;
    bus.req_write[i] = w;
    bus.req_blk[i] = b;
    bus.req_last[i] = l;
    bus.req_addr[16*i +: 16] = a;
    bus.req_wdata[32*i +: 32] = d;
  endtask
  task automatic do_reset();
    reset = 1'b1;
    bus.req_valid = '0;
    bus.req_write = '0;
    bus.req_blk = '0;
    bus.req_last = '0;
    bus.req_addr = '0;
    bus.req_wdata = '0;
    bus.reg_rwait = 1'b0;
    tick();
    reset = 1'b0;
  endtask
  function automatic int rr_pick(input logic [N-1:0] v, input int p);
    for (int k = 0; k < N; k++) if (v[(p + k) % N]) return (p + k) % N;
    return 3;
  endfunction

  task automatic test_reset();
    do_reset();
    checks++;
    if (bus.grant_id !== GRANT_NONE) begin errors++; $display("FAIL reset_grant: got %0d expected 3", bus.grant_id); end
    checks++;
    if ({bus.req_done, bus.req_err, bus.reg_wen, bus.blk_wstart, bus.blk_wen} !== '0) begin
      errors++; $display("FAIL reset_pulses: got %0h expected 0", {bus.req_done, bus.req_err, bus.reg_wen, bus.blk_wstart, bus.blk_wen});
    end
    checks++;
    if ({bus.req_rdata, bus.reg_raddr, bus.reg_waddr, bus.reg_wdata} !== '0) begin
      errors++; $display("FAIL reset_data: got %0h expected 0", {bus.req_rdata, bus.reg_raddr, bus.reg_waddr, bus.reg_wdata});
    end
    repeat (3) tick();
    checks++;
    if (bus.grant_id !== GRANT_NONE) begin errors++; $display("FAIL idle_grant: got %0d expected 3", bus.grant_id); end
  endtask

  task automatic test_read_latency();
    int n = 0;
    env_mem[mi(16'h0010)] = 32'hCAFE0001;
    set_req(REQ_ETH, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0010, 32'h0);
    while (n < 20) begin
      tick();
      n++;
      if (bus.req_done != '0) break;
    end
    checks++;
    if (n !== 3) begin errors++; $display("FAIL rd_latency: got %0d expected 3", n); end
    checks++;
    if (bus.req_done !== 3'b010) begin errors++; $display("FAIL rd_done: got %0b expected 010", bus.req_done); end
    checks++;
    if (bus.req_rdata !== 32'hCAFE0001) begin errors++; $display("FAIL rd_data: got %0h expected cafe0001", bus.req_rdata); end
    checks++;
    if (bus.reg_raddr !== 16'h0010) begin errors++; $display("FAIL rd_addr: got %0h expected 0010", bus.reg_raddr); end
    set_req(REQ_ETH, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 32'h0);
    tick();
  endtask

  task automatic test_round_robin();
    int seq[$];
    int gap = 0;
    int prev = 3;
    int g;
    do_reset();
    for (int i = 0; i < N; i++) set_req(i, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0100 + 16'(i), 32'h0);
    for (int c = 0; c < 60 && seq.size() < 6; c++) begin
      tick();
      g = int'(bus.grant_id);
      if (g != 3 && prev == 3) begin
        seq.push_back(g);
        if (seq.size() > 1) begin
          checks++;
          if (gap != 1) begin errors++; $display("FAIL rr_gap: got %0d idle cycles expected 1", gap); end
        end
        gap = 0;
      end
      if (g == 3) gap++;
      for (int i = 0; i < N; i++) bus.req_valid[i] = !bus.req_done[i];
      prev = g;
    end
    checks++;
    if (seq.size() != 6) begin errors++; $display("FAIL rr_count: got %0d grants expected 6", seq.size()); end
    for (int k = 0; k < seq.size(); k++) begin
      checks++;
      if (seq[k] != k % 3) begin errors++; $display("FAIL rr_order[%0d]: got %0d expected %0d", k, seq[k], k % 3); end
    end
    bus.req_valid = '0;
    repeat (6) tick();
  endtask

  task automatic test_block();
    int w = 0, gp = 0, wen_n = 0, ws = 0, bw = 0, bw_cyc = -1, g2_cyc = -1, c = 0;
    bit done2 = 0;
    do_reset();
    env_mem[mi(16'h2005)] = 32'h0000_2222;
    set_req(REQ_FW, 1'b1, 1'b1, 1'b1, 1'b0, 16'h1000, 32'hB10C0000);
    set_req(REQ_PS, 1'b1, 1'b0, 1'b0, 1'b0, 16'h2005, 32'h0);
    while (c < 80 && !done2) begin
      tick();
      c++;
      if (bus.blk_wstart) begin
        ws++;
        checks++;
        if (wen_n != 0) begin errors++; $display("FAIL blk_wstart_order: got %0d writes before start expected 0", wen_n); end
      end
      if (bus.reg_wen) begin
        checks++;
        if (bus.reg_waddr !== 16'h1000 + 16'(wen_n) || bus.reg_wdata !== 32'hB10C0000 + 32'(wen_n)) begin
          errors++; $display("FAIL blk_word[%0d]: got %0h/%0h expected %0h/%0h", wen_n, bus.reg_waddr, bus.reg_wdata,
                             16'h1000 + 16'(wen_n), 32'hB10C0000 + 32'(wen_n));
        end
        wen_n++;
      end
      if (bus.blk_wen) begin bw++; bw_cyc = c; end
      if (bus.grant_id == REQ_PS && g2_cyc < 0) g2_cyc = c;
      if (bus.req_done[REQ_PS]) begin
        done2 = 1;
        checks++;
        if (bus.req_rdata !== 32'h0000_2222) begin errors++; $display("FAIL blk_rd2: got %0h expected 2222", bus.req_rdata); end
        bus.req_valid[REQ_PS] = 1'b0;
      end
      if (bus.req_done[REQ_FW]) begin
        w++;
        if (w == 2) gp = 2;
      end
      if (gp > 0) begin
        bus.req_valid[REQ_FW] = 1'b0;
        gp--;
      end else set_req(REQ_FW, w < 4, 1'b1, 1'b1, w == 3, 16'h1000 + 16'(w), 32'hB10C0000 + 32'(w));
    end
    checks++;
    if (ws != 1) begin errors++; $display("FAIL blk_wstart_cnt: got %0d expected 1", ws); end
    checks++;
    if (wen_n != 4) begin errors++; $display("FAIL blk_wen_cnt: got %0d expected 4", wen_n); end
    checks++;
    if (bw != 1) begin errors++; $display("FAIL blk_end_cnt: got %0d expected 1", bw); end
    checks++;
    if (!done2 || bw_cyc < 0 || g2_cyc <= bw_cyc) begin
      errors++; $display("FAIL blk_preempt: got req2 grant cycle %0d expected after blk_wen cycle %0d", g2_cyc, bw_cyc);
    end
    tick();
  endtask

  task automatic test_rwait();
    int n = 0;
    env_mem[mi(16'h3003)] = 32'h1111_1111;
    set_req(REQ_PS, 1'b1, 1'b0, 1'b0, 1'b0, 16'h3003, 32'h0);
    bus.reg_rwait = 1'b1;
    while (n < 30) begin
      tick();
      n++;
      if (bus.req_done != '0) break;
      if (n == 7) begin
        bus.reg_rwait = 1'b0;
        env_mem[mi(16'h3003)] = 32'h2222_2222;
      end
    end
    checks++;
    if (n !== 8) begin errors++; $display("FAIL rwait_latency: got %0d expected 8", n); end
    checks++;
    if (bus.req_done !== 3'b100 || bus.req_err !== 3'b000) begin
      errors++; $display("FAIL rwait_done: got %0b/%0b expected 100/000", bus.req_done, bus.req_err);
    end
    checks++;
    if (bus.req_rdata !== 32'h2222_2222) begin errors++; $display("FAIL rwait_data: got %0h expected 22222222", bus.req_rdata); end
    bus.reg_rwait = 1'b0;
    set_req(REQ_PS, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 32'h0);
    tick();
  endtask

  task automatic test_reset_hold();
    int n = 0;
    bit bad = 0;
    do_reset();
    set_req(REQ_FW, 1'b1, 1'b1, 1'b1, 1'b0, 16'h4000, 32'h4444_0000);
    while (n < 10 && bus.req_done[REQ_FW] !== 1'b1) begin tick(); n++; end
    bus.req_valid[REQ_FW] = 1'b0;
    repeat (2) begin
      tick();
      checks++;
      if (bus.grant_id !== REQ_FW || bus.reg_wen !== 1'b0) begin
        errors++; $display("FAIL hold_state: got grant %0d wen %0b expected 0/0", bus.grant_id, bus.reg_wen);
      end
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++;
    if (bus.grant_id !== GRANT_NONE) begin errors++; $display("FAIL hold_reset_grant: got %0d expected 3", bus.grant_id); end
    checks++;
    if ({bus.req_done, bus.reg_wen, bus.blk_wstart, bus.blk_wen} !== '0) begin
      errors++; $display("FAIL hold_reset_pulses: got %0h expected 0", {bus.req_done, bus.reg_wen, bus.blk_wstart, bus.blk_wen});
    end
    repeat (5) begin tick(); if (bus.blk_wen) bad = 1; end
    checks++;
    if (bad) begin errors++; $display("FAIL hold_no_blk_wen: got blk_wen 1 expected 0"); end
    set_req(REQ_ETH, 1'b1, 1'b1, 1'b0, 1'b0, 16'h5005, 32'h5555AAAA);
    n = 0;
    while (n < 10) begin tick(); n++; if (bus.req_done != '0) break; end
    checks++;
    if (n !== 2 || bus.req_done !== 3'b010 || bus.reg_wen !== 1'b1 || bus.reg_waddr !== 16'h5005 || bus.reg_wdata !== 32'h5555AAAA) begin
      errors++; $display("FAIL post_reset_wr: got n=%0d done=%0b wen=%0b %0h/%0h expected 2/010/1/5005/5555aaaa",
                         n, bus.req_done, bus.reg_wen, bus.reg_waddr, bus.reg_wdata);
    end
    set_req(REQ_ETH, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 32'h0);
    tick();
  endtask

  task automatic test_timeout();
    int n = 0;
    bit seen = 0;
    do_reset();
    env_mem[mi(16'h6006)] = 32'hDEADBEEF;
    set_req(REQ_FW, 1'b1, 1'b0, 1'b0, 1'b0, 16'h6006, 32'h0);
    while (n < 10 && bus.req_done == '0) begin tick(); n++; end
    checks++;
    if (bus.req_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL to_pre_read: got %0h expected deadbeef", bus.req_rdata); end
    bus.req_valid[REQ_FW] = 1'b0;
    tick();
    bus.req_valid[REQ_FW] = 1'b1;
    bus.reg_rwait = 1'b1;
    n = 0;
`ifdef REG_ARB_TIMEOUT_EN
    while (n < 40) begin tick(); n++; if (bus.req_done != '0) break; end
    checks++;
    if (n !== 17 || bus.req_done !== 3'b001 || bus.req_err !== 3'b001 || bus.req_rdata !== 32'h0) begin
      errors++; $display("FAIL timeout: got n=%0d done=%0b err=%0b rdata=%0h expected 17/001/001/0",
                         n, bus.req_done, bus.req_err, bus.req_rdata);
    end
`else
    while (n < 100) begin tick(); n++; if (bus.req_done != '0 || bus.req_err != '0) seen = 1; end
    checks++;
    if (seen) begin errors++; $display("FAIL no_timeout: got a done/err within 100 cycles expected none"); end
`endif
    bus.reg_rwait = 1'b0;
    do_reset();
  endtask

  task automatic test_random();
    logic op_w [N];
    logic [15:0] op_a [N];
    logic [31:0] op_d [N];
    int gap [N];
    bit active [N];
    int mptr = 0, mgrant = 3, prev_g = 3, g, exp_g, ndone = 0, last_done = 0;
    logic [N-1:0] vb;
    do_reset();
    for (int k = 0; k < 256; k++) ref_mem[k] = env_mem[k];
    for (int i = 0; i < N; i++) begin gap[i] = 0; active[i] = 0; end
    for (int cyc = 0; cyc < 800; cyc++) begin
      bus.reg_rwait = ($urandom_range(0, 3) == 0);
      vb = bus.req_valid;
      tick();
      g = int'(bus.grant_id);
      if (g != prev_g && prev_g == 3) begin
        exp_g = rr_pick(vb, mptr);
        checks++;
        if (g != exp_g) begin errors++; $display("FAIL rnd_grant: got %0d expected %0d (valid %0b)", g, exp_g, vb); end
        mptr = (g + 1) % N;
        mgrant = g;
      end else if (g != prev_g && g != 3) begin
        checks++; errors++; $display("FAIL rnd_switch: got grant %0d -> %0d expected idle between", prev_g, g);
      end
      if (bus.req_done != '0) begin
        checks++;
        if (mgrant > 2 || bus.req_done !== 3'(1 << mgrant)) begin
          errors++; $display("FAIL rnd_done: got %0b expected grant %0d", bus.req_done, mgrant);
        end else if (op_w[mgrant]) begin
          checks++;
          if (bus.reg_wen !== 1'b1 || bus.reg_waddr !== op_a[mgrant] || bus.reg_wdata !== op_d[mgrant]) begin
            errors++; $display("FAIL rnd_write: got %0b %0h/%0h expected 1 %0h/%0h", bus.reg_wen, bus.reg_waddr,
                               bus.reg_wdata, op_a[mgrant], op_d[mgrant]);
          end
          ref_mem[mi(op_a[mgrant])] = op_d[mgrant];
        end else begin
          checks++;
          if (bus.req_rdata !== ref_mem[mi(op_a[mgrant])]) begin
            errors++; $display("FAIL rnd_read: got %0h expected %0h", bus.req_rdata, ref_mem[mi(op_a[mgrant])]);
          end
        end
        if (mgrant <= 2) begin
          active[mgrant] = 0;
          gap[mgrant] = $urandom_range(1, 4);
          bus.req_valid[mgrant] = 1'b0;
        end
        ndone++;
        last_done = cyc;
      end
      for (int i = 0; i < N; i++) if (!active[i]) begin
        if (gap[i] > 0) gap[i]--;
        else begin
          op_w[i] = 1'($urandom_range(0, 1));
          op_a[i] = 16'($urandom) & 16'hF00F;
          op_d[i] = $urandom;
          active[i] = 1;
          set_req(i, 1'b1, op_w[i], 1'b0, 1'b0, op_a[i], op_d[i]);
        end
      end
      prev_g = g;
      if (cyc - last_done > 100) begin
        checks++; errors++; $display("FAIL rnd_stall: got no done for 100 cycles expected progress");
        break;
      end
    end
    checks++;
    if (ndone < 20) begin errors++; $display("FAIL rnd_volume: got %0d completions expected at least 20", ndone); end
    bus.req_valid = '0;
    bus.reg_rwait = 1'b0;
    repeat (5) tick();
  endtask

  initial begin
    bus.req_valid = '0;
    bus.req_write = '0;
    bus.req_blk = '0;
    bus.req_last = '0;
    bus.req_addr = '0;
    bus.req_wdata = '0;
    bus.reg_rwait = 1'b0;
    for (int k = 0; k < 256; k++) env_mem[k] = $urandom;
    test_reset();
    test_read_latency();
    test_round_robin();
    test_block();
    test_rwait();
    test_reset_hold();
    test_timeout();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog expired");
  end
endmodule
